// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data (LSB first), optional parity, STOP_BITS stop.
// Latency: accept edge to o_Done pulse is (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT+1 cycles (P=1 with parity).
// Backpressure: o_Ready is high only in IDLE; i_Transmit at any other time is dropped, never queued.
// Optional parity bit is compiled in by defining UART_TX_PARITY_EN.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Transmit,
    input  logic [DATA_BITS-1:0] i_Data,
    output logic                 o_Ready,
    output logic                 o_Active,
    output logic                 o_TxD,
    output logic                 o_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     idx_nxt;
    logic [DATA_BITS-1:0] shadow_q, shadow_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic                 active_q, active_d;
    logic                 bit_end;

    // bit_end marks the last cycle of the current bit period
    assign bit_end = (cnt_q == CNT_LAST);
    assign idx_nxt = idx_q + IDX_W'(1);

    // next-state, next-line-level and next-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tx_d     = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                idx_d = '0;
                if (i_Transmit) begin
                    shadow_d = i_Data;
                    state_d  = S_START;
                    tx_d     = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shadow_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = (^shadow_q) ^ (PARITY_ODD != 0);
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = shadow_q[idx_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                // unreachable encodings recover to a quiet idle line
                tx_d    = 1'b1;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        done_d   = (state_d == S_DONE);
        ready_d  = (state_d == S_IDLE);
`ifdef UART_TX_PARITY_EN
        active_d = (state_d == S_START) || (state_d == S_DATA) ||
                   (state_d == S_PARITY) || (state_d == S_STOP);
`else
        active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
`endif
    end

    // state, counters, shadow data and registered outputs; reset idles the line at once
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            active_q <= active_d;
        end
    end

    assign o_TxD    = tx_q;
    assign o_Done   = done_q;
    assign o_Ready  = ready_q;
    assign o_Active = active_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
module tb_uart_tx_cfg;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int A_LEN = (1 + 8 + P + 1) * CPB + 1;
    localparam int B_LEN = (1 + 7 + P + 2) * CPB + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_req, a_rdy, a_act, a_txd, a_done;
    logic [7:0] a_din;
    logic       b_req, b_rdy, b_act, b_txd, b_done;
    logic [6:0] b_din;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Transmit(a_req), .i_Data(a_din),
        .o_Ready(a_rdy), .o_Active(a_act), .o_TxD(a_txd), .o_Done(a_done));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Transmit(b_req), .i_Data(b_din),
        .o_Ready(b_rdy), .o_Active(b_act), .o_TxD(b_txd), .o_Done(b_done));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: {txd, done, ready, active} for cycle c (1-based) after an accept.
    function automatic logic [3:0] exp_out(input int c, input logic [8:0] d, input int db,
                                           input int sb, input bit odd);
        int nb;
        int k;
        logic tx;
        logic [8:0] m;
        nb = 1 + db + P + sb;
        if (c > nb * CPB) return 4'b1100;
        k = (c - 1) / CPB;
        m = 9'((1 << db) - 1);
        if (k == 0)                     tx = 1'b0;
        else if (k <= db)               tx = d[k-1];
        else if (P == 1 && k == db + 1) tx = (^(d & m)) ^ odd;
        else                            tx = 1'b1;
        return {tx, 1'b0, 1'b0, 1'b1};
    endfunction

    bit         a_busy = 0, b_busy = 0;
    int         a_c, b_c;
    logic [8:0] a_d, b_d;
    int         a_done_at = -1, b_done_at = -1;
    logic       a_trace [0:127];
    logic       b_trace [0:127];

    // Single compare process: advance the model at each edge, check both DUTs 1 ns later.
    always @(posedge clk) begin
        logic [3:0] ea, eb;
        if (!rst_n) begin
            a_busy = 0;
            b_busy = 0;
        end else begin
            if (a_busy && a_c == A_LEN) a_busy = 0;
            else if (!a_busy && a_req) begin
                a_busy = 1; a_c = 0; a_d = {1'b0, a_din}; a_done_at = -1;
            end
            if (b_busy && b_c == B_LEN) b_busy = 0;
            else if (!b_busy && b_req) begin
                b_busy = 1; b_c = 0; b_d = {2'b0, b_din}; b_done_at = -1;
            end
        end
        #1;
        if (a_busy) begin
            a_c++;
            ea = exp_out(a_c, a_d, 8, 1, 1'b0);
            if (a_c < 128) a_trace[a_c] = a_txd;
            if (a_done) a_done_at = a_c;
        end else ea = 4'b1010;
        chk("a_outputs", {a_txd, a_done, a_rdy, a_act}, ea);
        if (b_busy) begin
            b_c++;
            eb = exp_out(b_c, b_d, 7, 2, 1'b1);
            if (b_c < 128) b_trace[b_c] = b_txd;
            if (b_done) b_done_at = b_c;
        end else eb = 4'b1010;
        chk("b_outputs", {b_txd, b_done, b_rdy, b_act}, eb);
    end

    task automatic wait_done(input bit which, input string nm);
        int n = 0;
        while (!(which ? b_done : a_done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_timeout"}, 32'(n < 300), 32'd1);
    endtask

    function automatic logic [7:0] a_byte();
        logic [7:0] v;
        for (int k = 1; k <= 8; k++) v[k-1] = a_trace[4*k+2];
        return v;
    endfunction

    initial begin
        logic [9:0] seq;
        int gap;
        int z;
        rst_n = 1'b0; a_req = 1'b0; a_din = '0; b_req = 1'b0; b_din = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd",   a_txd,  1);
        chk("rst_ready", a_rdy,  1);
        chk("rst_active", a_act, 0);
        chk("rst_done",  a_done, 0);

        // request already pending when reset releases: accepted on the first edge
`ifdef UART_TX_PARITY_EN
        a_din = 8'h07;
`else
        a_din = 8'hA5;
`endif
        a_req = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        chk("first_edge_accept", a_act, 1);
        wait_done(0, "a_first");
`ifdef UART_TX_PARITY_EN
        chk("a07_parity_bit", a_trace[38], 1);
        chk("a07_done_cycle", a_done_at, 45);
`else
        for (int k = 0; k < 10; k++) seq[k] = a_trace[4*k+2];
        chk("a5_bit_sequence", seq, 10'b1101001010);
        chk("a5_done_cycle", a_done_at, 41);
`endif
        @(negedge clk);

        // 7 data bits, 2 stop bits on the second instance
        b_din = 7'h7F; b_req = 1'b1;
        @(negedge clk);
        b_req = 1'b0;
        wait_done(1, "b");
        z = 0;
        for (int c = 1; c <= (B_LEN - 1); c++) if (b_trace[c] == 1'b0) z++;
        chk("b7f_zero_cycles", z, (P == 1) ? 8 : 4);
        chk("b7f_done_cycle", b_done_at, (P == 1) ? 45 : 41);
        @(negedge clk);

        // back-to-back with request held high
        a_din = 8'h55; a_req = 1'b1;
        @(negedge clk);
        a_din = 8'h0F;
        chk("b2b_first_data", a_d, 9'h055);
        wait_done(0, "b2b_first");
        gap = 0;
        while (a_txd && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        a_req = 1'b0;
        chk("b2b_mark_gap", gap, 2);
        @(negedge clk);
        wait_done(0, "b2b_second");
        chk("b2b_second_byte", a_byte(), 8'h0F);
        @(negedge clk);

        // mid-frame request and data change are ignored
        a_din = 8'h3C; a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        repeat (10) @(negedge clk);
        a_din = 8'hFF; a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        wait_done(0, "ign");
        chk("ign_byte", a_byte(), 8'h3C);
        repeat (60) @(negedge clk);
        chk("ign_no_second_frame", a_act, 0);

        // asynchronous reset during a data bit
        a_din = 8'h00; a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_pre_txd", a_txd, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_txd",    a_txd, 1);
        chk("abort_ready",  a_rdy, 1);
        chk("abort_active", a_act, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_no_done_idle", a_rdy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417, clock cycles per bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 = even, 1 = odd; used only as set out in Configuration.
REQ-005 SHALL size the bit-period counter internally as $clog2(CLKS_PER_BIT) bits, with no width parameter exposed.
REQ-006 SHALL have port i_Clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_Rst_n, input, 1 bit: asynchronous reset, active low.
REQ-008 SHALL have port i_Transmit, input, 1 bit: request to send i_Data.
REQ-009 SHALL have port i_Data, input, DATA_BITS bits: frame payload, sent LSB first.
REQ-010 SHALL have port o_Ready, output, 1 bit: high only in IDLE; a request is accepted only while it is high.
REQ-011 SHALL have port o_Active, output, 1 bit: high from START through STOP.
REQ-012 SHALL have port o_TxD, output, 1 bit: serial line, registered, idle level 1.
REQ-013 SHALL have port o_Done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY, STOP and DONE.
REQ-015 Accept: at a rising edge with i_Transmit=1 and state IDLE, SHALL latch i_Data into a shadow register and enter START.
REQ-016 Bit timing: o_TxD SHALL change to the start bit (0) on that accepting edge; each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-017 After START, SHALL enter DATA and send shadow bits 0..DATA_BITS-1 in order; the bit index SHALL reset to 0 on entry to DATA.
REQ-018 After the last data bit, SHALL go to PARITY if it is compiled in, otherwise to STOP.
REQ-019 STOP SHALL drive o_TxD=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 DONE SHALL last exactly 1 cycle with o_TxD=1, o_Done=1 and o_Ready=0, then go to IDLE.
REQ-021 o_Ready SHALL equal (state==IDLE); o_Active SHALL equal (state in START/DATA/PARITY/STOP).
REQ-022 Latency: accept to o_Done SHALL be (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT+1 cycles, where P=1 if parity is compiled in, else 0.
REQ-023 Back-to-back: with i_Transmit held high, the next accept SHALL occur on the IDLE cycle after DONE, giving exactly 2 cycles of mark (o_TxD=1) between frames.
REQ-024 i_Transmit outside IDLE SHALL be ignored and not queued; i_Data changes after acceptance SHALL NOT affect the frame in flight.
REQ-025 An illegal state encoding SHALL return to IDLE on the next edge with o_TxD=1.

Reset
REQ-026 i_Rst_n=0 SHALL asynchronously force state IDLE, bit counter 0, bit index 0, shadow register 0, o_TxD=1, o_Done=0, o_Active=0 and o_Ready=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no o_Done pulse; the line SHALL go to 1 immediately.
REQ-028 After i_Rst_n rises, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: PARITY state present; parity bit = XOR of data bits, XOR PARITY_ODD; held for CLKS_PER_BIT cycles between DATA and STOP.
REQ-030 Macro UART_TX_PARITY_EN undefined: no PARITY state or logic; PARITY_ODD SHALL be ignored; DATA SHALL be followed directly by STOP.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-031 8N1, send 0xA5 -> o_TxD reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; o_Done high on cycle 41 only after the accept.
REQ-032 UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; o_Done on cycle 45.
REQ-033 DATA_BITS=7, STOP_BITS=2, send 0x7F -> 0, seven 1s, then 8 stop cycles of 1; o_Done on cycle 41.
REQ-034 i_Transmit held high, i_Data=0x55 then 0x0F -> two full frames separated by exactly 2 mark cycles; second frame carries 0x0F.
REQ-035 During a 0x3C frame, pulse i_Transmit and change i_Data to 0xFF -> frame still carries 0x3C; no second frame is sent.
REQ-036 Drop i_Rst_n during the data bit of a frame -> o_TxD=1, o_Ready=1, o_Active=0 without waiting for a clock edge; no o_Done pulse.
